// File: rtl/sync_fifo_pkg.sv
// Shared sizing constants for the single-clock FIFO and its storage array.
package sync_fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 16;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read with read enable.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Array contents are deliberately left unreset; only the output register clears.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: extended-pointer full/empty flags, registered read data,
// and one-cycle error pulses for writes while full and reads while empty.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_wr_en,
    input  logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  fifo_full,
    input  logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_empty,
    output logic                  fifo_wr_err,
    output logic                  fifo_rd_err
);
    // Handshake: a write is taken on a rising edge when fifo_wr_en is high and
    // fifo_full is low (fifo_full acts as not-ready); a read is taken when
    // fifo_rd_en is high and fifo_empty is low, with data on fifo_rd_data the
    // following cycle. Both flags reflect state before the edge, so there is
    // no fall-through and no write into a slot freed in the same cycle.

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                wr_err_q, wr_err_d;
    logic                rd_err_q, rd_err_d;
    logic                wr_accept;
    logic                rd_accept;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                        (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

    assign wr_accept = fifo_wr_en && !fifo_full;
    assign rd_accept = fifo_rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_err_d = fifo_wr_en && fifo_full;
        rd_err_d = fifo_rd_en && fifo_empty;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign fifo_wr_err = wr_err_q;
    assign fifo_rd_err = rd_err_q;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (fifo_rd_data)
    );
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference of a 16-entry FIFO.
module tb_sync_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_en = 1'b0;
    logic [DW-1:0] fifo_wr_data = '0;
    logic          fifo_full;
    logic          fifo_rd_en = 1'b0;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_wr_err;
    logic          fifo_rd_err;

    // Reference state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rd_data = '0;
    logic          exp_wr_err = 1'b0;
    logic          exp_rd_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    sync_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_wr_err  (fifo_wr_err),
        .fifo_rd_err  (fifo_rd_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Packed views: {rd_data, full, empty, wr_err, rd_err}
    function automatic logic [DW+3:0] act_vec();
        return {fifo_rd_data, fifo_full, fifo_empty, fifo_wr_err, fifo_rd_err};
    endfunction

    function automatic logic [DW+3:0] exp_vec();
        return {exp_rd_data, exp_q.size() == DEPTH, exp_q.size() == 0, exp_wr_err, exp_rd_err};
    endfunction

    // Driver: apply inputs for one clock, update the reference, settle 1 time unit past the edge.
    task automatic drive(input logic rst, input logic wr, input logic [DW-1:0] d, input logic rd);
        int sz;
        rst_n        = rst;
        fifo_wr_en   = wr;
        fifo_wr_data = d;
        fifo_rd_en   = rd;
        sz = exp_q.size();
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            exp_rd_data = '0;
            exp_wr_err  = 1'b0;
            exp_rd_err  = 1'b0;
        end else begin
            exp_wr_err = wr && (sz == DEPTH);
            exp_rd_err = rd && (sz == 0);
            if (rd && sz != 0) exp_rd_data = exp_q.pop_front();
            if (wr && sz != DEPTH) exp_q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (10) drive(1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_empty);
        else n_pass++;
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full);
        else n_pass++;
        n_checks++;
        if (fifo_rd_data !== 16'h0000) $display("FAIL reset_rd_data: got %h want 0000", fifo_rd_data);
        else n_pass++;
        n_checks++;
        if ({fifo_wr_err, fifo_rd_err} !== 2'b00)
            $display("FAIL reset_err: got %b%b want 00", fifo_wr_err, fifo_rd_err);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b1, DW'(i), 1'b0);
            n_checks++;
            if (fifo_full !== (i == DEPTH) || fifo_wr_err !== 1'b0 || fifo_empty !== 1'b0)
                $display("FAIL fill_%0d: full=%b wr_err=%b empty=%b want full=%b wr_err=0 empty=0",
                         i, fifo_full, fifo_wr_err, fifo_empty, (i == DEPTH));
            else n_pass++;
        end
        drive(1'b1, 1'b1, 16'd17, 1'b0);
        n_checks++;
        if (fifo_wr_err !== 1'b1 || fifo_full !== 1'b1)
            $display("FAIL fill_overflow: wr_err=%b full=%b want 1 1", fifo_wr_err, fifo_full);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if (fifo_wr_err !== 1'b0 || fifo_full !== 1'b1)
            $display("FAIL fill_err_pulse: wr_err=%b full=%b want 0 1", fifo_wr_err, fifo_full);
        else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1);
            n_checks++;
            if (fifo_rd_data !== DW'(i) || fifo_rd_err !== 1'b0)
                $display("FAIL drain_%0d: rd_data=%h rd_err=%b want %h 0", i, fifo_rd_data, fifo_rd_err, DW'(i));
            else n_pass++;
        end
        n_checks++;
        if (fifo_empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", fifo_empty);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (fifo_rd_err !== 1'b1 || fifo_rd_data !== 16'd16)
            $display("FAIL drain_underflow: rd_err=%b rd_data=%h want 1 0010", fifo_rd_err, fifo_rd_data);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b0);
        n_checks++;
        if (fifo_rd_err !== 1'b0) $display("FAIL drain_err_pulse: got %b want 0", fifo_rd_err);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [DW-1:0] wdata = 16'h1000;
        logic [DW-1:0] next_out = 16'h1000;
        logic          rd;
        int            n_out = 0;
        int            bad = 0;
        for (int c = 0; c < 200; c++) begin
            rd = !fifo_empty;
            drive(1'b1, 1'b1, wdata, rd);
            wdata++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL stream_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (rd) begin
                if (fifo_rd_data !== next_out || fifo_wr_err || fifo_rd_err) begin
                    bad++;
                    $display("FAIL stream_seq cyc %0d: rd_data=%h errs=%b%b want %h 00",
                             c, fifo_rd_data, fifo_wr_err, fifo_rd_err, next_out);
                end
                next_out++;
                n_out++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL stream_total: got %0d bad cycles want 0", bad);
        else n_pass++;
        n_checks++;
        if (n_out <= 2 * DEPTH) $display("FAIL stream_wrap: got %0d reads want > %0d", n_out, 2 * DEPTH);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [DW-1:0] first;
        logic [DW-1:0] val;
        for (int i = 0; i < 4 * DEPTH && !fifo_empty; i++) drive(1'b1, 1'b0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b1, DW'($urandom_range(0, 65535)), 1'b0);
        first = exp_q[0];
        // Full: read served, write rejected
        drive(1'b1, 1'b1, 16'hDEAD, 1'b1);
        n_checks++;
        if (fifo_wr_err !== 1'b1 || fifo_rd_data !== first || fifo_full !== 1'b0)
            $display("FAIL bound_full_rw: wr_err=%b rd_data=%h full=%b want 1 %h 0",
                     fifo_wr_err, fifo_rd_data, fifo_full, first);
        else n_pass++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            val = exp_q[0];
            drive(1'b1, 1'b0, '0, 1'b1);
            n_checks++;
            if (fifo_rd_data !== val) $display("FAIL bound_drain_%0d: got %h want %h", i, fifo_rd_data, val);
            else n_pass++;
        end
        n_checks++;
        if (fifo_empty !== 1'b1) $display("FAIL bound_count15: empty=%b want 1 after 15 reads", fifo_empty);
        else n_pass++;
        // Empty: write stored, read rejected
        val = fifo_rd_data;
        drive(1'b1, 1'b1, 16'h5A5A, 1'b1);
        n_checks++;
        if (fifo_rd_err !== 1'b1 || fifo_empty !== 1'b0 || fifo_rd_data !== val)
            $display("FAIL bound_empty_rw: rd_err=%b empty=%b rd_data=%h want 1 0 %h",
                     fifo_rd_err, fifo_empty, fifo_rd_data, val);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (fifo_rd_data !== 16'h5A5A || fifo_empty !== 1'b1)
            $display("FAIL bound_count1: rd_data=%h empty=%b want 5a5a 1", fifo_rd_data, fifo_empty);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, DW'($urandom_range(0, 65535)), 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
        n_checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_rd_data !== 16'h0000)
            $display("FAIL midreset_state: empty=%b full=%b rd_data=%h want 1 0 0000",
                     fifo_empty, fifo_full, fifo_rd_data);
        else n_pass++;
        drive(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (fifo_rd_err !== 1'b1) $display("FAIL midreset_rd_err: got %b want 1", fifo_rd_err);
        else n_pass++;
        drive(1'b1, 1'b1, 16'hBEEF, 1'b0);
        drive(1'b1, 1'b1, 16'hCAFE, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b1);
        n_checks++;
        if (fifo_rd_data !== 16'hBEEF) $display("FAIL midreset_first: got %h want beef", fifo_rd_data);
        else n_pass++;
    endtask

    task automatic test_random();
        int wr_pct;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            wr_pct = ((c / 50) % 2 == 0) ? 80 : 20;
            drive(1'b1, $urandom_range(0, 99) < wr_pct, DW'($urandom_range(0, 65535)),
                  $urandom_range(0, 99) < (100 - wr_pct));
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL random_total: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
